register_file: RTL and testbench



---
 rtl/register_file_if.sv | 41 ++++
 rtl/register_file.sv | 100 ++++++++++
 tb/tb_register_file.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register-file port bundle: one write port, two read ports and the busy/reservation scoreboard.
// The requester drives the master side; register_file takes the slave side.
interface register_file_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic            store;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] data;

    logic            enable_a;
    logic [AW-1:0]   addr_a;
    logic [XLEN-1:0] a_out;
    logic            a_busy;

    logic            enable_b;
    logic [AW-1:0]   addr_b;
    logic [XLEN-1:0] b_out;
    logic            b_busy;

    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            flush;
    logic [AW:0]     busy_count;

    modport master (
        output store, wr_addr, data,
        output enable_a, addr_a, enable_b, addr_b,
        output rsv_en, rsv_addr, flush,
        input  a_out, a_busy, b_out, b_busy, busy_count
    );

    modport slave (
        input  store, wr_addr, data,
        input  enable_a, addr_a, enable_b, addr_b,
        input  rsv_en, rsv_addr, flush,
        output a_out, a_busy, b_out, b_busy, busy_count
    );
endinterface

// File: rtl/register_file.sv
// Two-read/one-write register file with write-first bypass, a per-register busy scoreboard
// and a registered count of busy registers. Register 0 is hardwired to zero and never busy.
module register_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input logic            clk,
    input logic            reset_n,
    register_file_if.slave rf
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic wr_valid_c;
    logic rsv_valid_c;
    logic cnt_inc_c;
    logic cnt_dec_c;

    assign wr_valid_c  = rf.store  && (rf.wr_addr  != '0);
    assign rsv_valid_c = rf.rsv_en && (rf.rsv_addr != '0);

    // Next state: writeback clears busy, a same-cycle reserve re-sets it, flush clears everything.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        count_d   = count_q;
        cnt_inc_c = 1'b0;
        cnt_dec_c = 1'b0;

        if (wr_valid_c) begin
            regs_d[rf.wr_addr] = rf.data;
            busy_d[rf.wr_addr] = 1'b0;
        end
        if (rsv_valid_c) begin
            busy_d[rf.rsv_addr] = 1'b1;
        end

        cnt_inc_c = rsv_valid_c && !busy_q[rf.rsv_addr];
        cnt_dec_c = wr_valid_c && busy_q[rf.wr_addr]
                    && !(rsv_valid_c && (rf.rsv_addr == rf.wr_addr));

        if (rf.flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            count_d = count_q + CW'(cnt_inc_c) - CW'(cnt_dec_c);
        end

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Read port A: write-first bypass, register 0 reads zero, disabled port reads zero.
    always_comb begin
        rf.a_out = '0;
        if (rf.enable_a) begin
            if (wr_valid_c && (rf.wr_addr == rf.addr_a)) begin
                rf.a_out = rf.data;
            end else if (rf.addr_a != '0) begin
                rf.a_out = regs_q[rf.addr_a];
            end
        end
    end

    always_comb begin
        rf.b_out = '0;
        if (rf.enable_b) begin
            if (wr_valid_c && (rf.wr_addr == rf.addr_b)) begin
                rf.b_out = rf.data;
            end else if (rf.addr_b != '0) begin
                rf.b_out = regs_q[rf.addr_b];
            end
        end
    end

    // Busy flags reflect registered state only; same-cycle reserve/writeback are not bypassed.
    assign rf.a_busy     = rf.enable_a && busy_q[rf.addr_a];
    assign rf.b_busy     = rf.enable_b && busy_q[rf.addr_b];
    assign rf.busy_count = count_q;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vectors on a 32x32 instance, then a modelled
// random run on a 16-bit, 8-register instance.
module tb_register_file;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    register_file_if #(.XLEN(32), .NREGS(32)) bif ();
    register_file_if #(.XLEN(16), .NREGS(8))  sif ();

    register_file #(.XLEN(32), .NREGS(32)) dut (
        .clk    (clk),
        .reset_n(rst_n),
        .rf     (bif.slave)
    );

    register_file #(.XLEN(16), .NREGS(8)) dut_s (
        .clk    (clk),
        .reset_n(rst_n),
        .rf     (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [4:0] wa, input logic [31:0] d,
                         input logic ea, input logic [4:0] aa,
                         input logic eb, input logic [4:0] ab,
                         input logic rs, input logic [4:0] ra, input logic fl);
        bif.store    = st;
        bif.wr_addr  = wa;
        bif.data     = d;
        bif.enable_a = ea;
        bif.addr_a   = aa;
        bif.enable_b = eb;
        bif.addr_b   = ab;
        bif.rsv_en   = rs;
        bif.rsv_addr = ra;
        bif.flush    = fl;
    endtask

    // Reference model for the small instance
    logic [15:0] m_regs [8];
    logic [7:0]  m_busy;

    function automatic logic [15:0] m_read(input logic en, input logic [2:0] addr,
                                           input logic st, input logic [2:0] wa,
                                           input logic [15:0] d);
        logic [15:0] r;
        r = 16'h0;
        if (en) begin
            if (st && (wa != 3'd0) && (wa == addr)) r = d;
            else if (addr != 3'd0)                  r = m_regs[addr];
        end
        return r;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(0, 0, 0, 1, 5, 1, 5, 0, 0, 0);
        sif.store = 0; sif.wr_addr = '0; sif.data = '0;
        sif.enable_a = 0; sif.addr_a = '0; sif.enable_b = 0; sif.addr_b = '0;
        sif.rsv_en = 0; sif.rsv_addr = '0; sif.flush = 0;
        #1;
        check_eq("rst_count", 64'(bif.busy_count), 64'd0);
        check_eq("rst_a_out", 64'(bif.a_out), 64'd0);
        check_eq("rst_a_busy", 64'(bif.a_busy), 64'd0);
        tick();
        rst_n = 1'b1;

        // Write-first bypass, then registered value
        drive(1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0, 0);
        #1 check_eq("byp_a", 64'(bif.a_out), 64'hDEADBEEF);
        tick();
        drive(0, 0, 0, 1, 5, 1, 5, 0, 0, 0);
        #1 check_eq("r5_a", 64'(bif.a_out), 64'hDEADBEEF);
        check_eq("r5_b", 64'(bif.b_out), 64'hDEADBEEF);
        drive(0, 0, 0, 0, 5, 0, 5, 0, 0, 0);
        #1 check_eq("en_a_off", 64'(bif.a_out), 64'd0);
        check_eq("en_b_off", 64'(bif.b_out), 64'd0);

        // Register 0 stays zero; no bypass, no reserve
        drive(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 1, 0, 0);
        #1 check_eq("r0_nobyp_a", 64'(bif.a_out), 64'd0);
        check_eq("r0_nobyp_b", 64'(bif.b_out), 64'd0);
        tick();
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        #1 check_eq("r0_a", 64'(bif.a_out), 64'd0);
        check_eq("r0_b", 64'(bif.b_out), 64'd0);
        check_eq("r0_rsv_count", 64'(bif.busy_count), 64'd0);

        // Reserve r3 then r7
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        tick();
        drive(0, 0, 0, 1, 7, 0, 0, 1, 7, 0);
        #1 check_eq("busy_no_byp", 64'(bif.a_busy), 64'd0);
        tick();
        drive(0, 0, 0, 1, 3, 1, 4, 0, 0, 0);
        #1 check_eq("cnt_2", 64'(bif.busy_count), 64'd2);
        check_eq("a_busy_r3", 64'(bif.a_busy), 64'd1);
        check_eq("b_busy_r4", 64'(bif.b_busy), 64'd0);

        // Writeback and reserve on r3 together: reserve wins
        drive(1, 3, 32'h33, 1, 3, 0, 0, 1, 3, 0);
        tick();
        drive(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        #1 check_eq("rsv_wins_cnt", 64'(bif.busy_count), 64'd2);
        check_eq("rsv_wins_busy", 64'(bif.a_busy), 64'd1);
        check_eq("r3_data", 64'(bif.a_out), 64'h33);

        // Reserve r9 while writing back r7
        drive(1, 7, 32'h77, 0, 0, 0, 0, 1, 9, 0);
        tick();
        drive(0, 0, 0, 1, 9, 1, 7, 0, 0, 0);
        #1 check_eq("swap_cnt", 64'(bif.busy_count), 64'd2);
        check_eq("swap_r9_busy", 64'(bif.a_busy), 64'd1);
        check_eq("swap_r7_busy", 64'(bif.b_busy), 64'd0);
        check_eq("r7_data", 64'(bif.b_out), 64'h77);

        // Flush beats reserve; store still writes
        drive(1, 4, 32'h44, 0, 0, 0, 0, 1, 4, 1);
        tick();
        drive(0, 0, 0, 1, 4, 1, 3, 0, 0, 0);
        #1 check_eq("flush_cnt", 64'(bif.busy_count), 64'd0);
        check_eq("flush_r4_busy", 64'(bif.a_busy), 64'd0);
        check_eq("flush_r3_busy", 64'(bif.b_busy), 64'd0);
        check_eq("flush_r4_data", 64'(bif.a_out), 64'h44);
        drive(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        #1 check_eq("flush_r9_busy", 64'(bif.a_busy), 64'd0);

        // Decrement paths
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        tick();
        drive(1, 2, 32'h22, 0, 0, 0, 0, 1, 6, 0);
        tick();
        drive(0, 0, 0, 1, 6, 1, 2, 0, 0, 0);
        #1 check_eq("net0_cnt", 64'(bif.busy_count), 64'd2);
        check_eq("net0_r6_busy", 64'(bif.a_busy), 64'd1);
        check_eq("net0_r2_busy", 64'(bif.b_busy), 64'd0);
        drive(1, 5, 32'h55, 0, 0, 0, 0, 1, 6, 0);
        tick();
        drive(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
        #1 check_eq("dec_cnt", 64'(bif.busy_count), 64'd1);
        tick();
        drive(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        #1 check_eq("wb_idle_cnt", 64'(bif.busy_count), 64'd1);
        check_eq("wb_idle_data", 64'(bif.a_out), 64'h99);

        // Async reset mid-cycle
        drive(1, 12, 32'h1234, 0, 0, 0, 0, 1, 12, 0);
        tick();
        drive(0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
        #1 check_eq("r12_data", 64'(bif.a_out), 64'h1234);
        check_eq("r12_cnt", 64'(bif.busy_count), 64'd2);
        #2 rst_n = 1'b0;
        #1 check_eq("arst_r12", 64'(bif.a_out), 64'd0);
        check_eq("arst_cnt", 64'(bif.busy_count), 64'd0);
        check_eq("arst_busy", 64'(bif.a_busy), 64'd0);
        drive(1, 6, 32'hAAAA, 1, 6, 0, 0, 1, 6, 1);
        #1 check_eq("arst_byp", 64'(bif.a_out), 64'hAAAA);
        drive(1, 6, 32'hAAAA, 0, 6, 0, 0, 1, 6, 1);
        #1 check_eq("arst_en_off", 64'(bif.a_out), 64'd0);
        tick();
        drive(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        #1 check_eq("arst_ign_data", 64'(bif.a_out), 64'd0);
        check_eq("arst_ign_cnt", 64'(bif.busy_count), 64'd0);
        rst_n = 1'b1;
        tick();
        #1 check_eq("post_rst_cnt", 64'(bif.busy_count), 64'd0);
        check_eq("post_rst_r6", 64'(bif.a_out), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random run against the model on the small instance
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_busy = 8'h0;
        for (int c = 0; c < 10000; c++) begin
            logic st, rs, fl, ea, eb;
            logic [2:0] wa, ra, aa, ab;
            logic [15:0] d;
            st = 1'($urandom);  wa = 3'($urandom); d  = 16'($urandom);
            rs = 1'($urandom);  ra = 3'($urandom);
            fl = ($urandom_range(0, 15) == 0);
            ea = ($urandom_range(0, 3) != 0); aa = 3'($urandom);
            eb = ($urandom_range(0, 3) != 0); ab = 3'($urandom);
            sif.store = st; sif.wr_addr = wa; sif.data = d;
            sif.rsv_en = rs; sif.rsv_addr = ra; sif.flush = fl;
            sif.enable_a = ea; sif.addr_a = aa; sif.enable_b = eb; sif.addr_b = ab;
            #1;
            check_eq("rnd_a_out", 64'(sif.a_out), 64'(m_read(ea, aa, st, wa, d)));
            check_eq("rnd_b_out", 64'(sif.b_out), 64'(m_read(eb, ab, st, wa, d)));
            check_eq("rnd_a_busy", 64'(sif.a_busy), 64'(ea & m_busy[aa]));
            check_eq("rnd_b_busy", 64'(sif.b_busy), 64'(eb & m_busy[ab]));
            check_eq("rnd_count", 64'(sif.busy_count), 64'($countones(m_busy)));
            if (st && wa != 3'd0) begin
                m_regs[wa] = d;
                m_busy[wa] = 1'b0;
            end
            if (rs && ra != 3'd0) m_busy[ra] = 1'b1;
            if (fl) m_busy = 8'h0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
